// File: rtl/key_display_mux.sv
`default_nettype none
// ============================================================================
// Module      : key_display_mux
// Description : Two-digit multiplexed 7-segment display for a hex keypad.
//               Keeps the newest and previous key, and time-multiplexes them
//               onto a common-anode display. Blank gaps between digit slots
//               suppress ghosting.
// Revision    : 1.0 - initial release
// ============================================================================
module key_display_mux #(
  parameter int REFRESH_CYCLES = 60000,
  parameter int BLANK_CYCLES   = 200
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] input_key,
  input  logic       valid_input,
  output logic [3:0] current_value,
  output logic [6:0] seg,
  output logic [1:0] anode
);

  localparam int c_max_cycles = (REFRESH_CYCLES > BLANK_CYCLES) ? REFRESH_CYCLES : BLANK_CYCLES;
  localparam int c_cnt_w      = (c_max_cycles > 1) ? $clog2(c_max_cycles) : 1;
  localparam logic [c_cnt_w-1:0] c_refresh_last = c_cnt_w'(REFRESH_CYCLES - 1);
  localparam logic [c_cnt_w-1:0] c_blank_last   = c_cnt_w'(BLANK_CYCLES - 1);
  localparam logic [6:0]         c_seg_off      = 7'b1111111;
  localparam logic [1:0]         c_anode_off    = 2'b11;

  typedef enum logic [1:0] {
    SHOW_NEW = 2'd0,
    BLANK_1  = 2'd1,
    SHOW_OLD = 2'd2,
    BLANK_2  = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [c_cnt_w-1:0] cnt_q, cnt_d;
  logic [3:0]         new_digit_q, new_digit_d;
  logic [3:0]         old_digit_q, old_digit_d;
  logic               new_valid_q, new_valid_d;
  logic               old_valid_q, old_valid_d;
  logic [6:0]         seg_q, seg_d;
  logic [1:0]         anode_q, anode_d;
  logic               is_show;
  logic               at_terminal;

  // Hex to active-low segments, bit order {g,f,e,d,c,b,a}
  function automatic logic [6:0] decode(input logic [3:0] hex);
    logic [6:0] s;
    s = c_seg_off;
    case (hex)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      4'hF: s = 7'b0001110;
      default: s = c_seg_off;
    endcase
    return s;
  endfunction

  // Next-state logic: key history shift, slot sequencing and the display
  // outputs derived from the next state so they move on the same edge
  always_comb begin
    new_digit_d = new_digit_q;
    old_digit_d = old_digit_q;
    new_valid_d = new_valid_q;
    old_valid_d = old_valid_q;
    state_d     = state_q;
    cnt_d       = cnt_q;
    anode_d     = c_anode_off;
    seg_d       = c_seg_off;

    if (valid_input) begin
      old_digit_d = new_digit_q;
      old_valid_d = new_valid_q;
      new_digit_d = input_key;
      new_valid_d = 1'b1;
    end

    is_show     = (state_q == SHOW_NEW) || (state_q == SHOW_OLD);
    at_terminal = is_show ? (cnt_q == c_refresh_last) : (cnt_q == c_blank_last);

    if (at_terminal) begin
      cnt_d = '0;
      case (state_q)
        SHOW_NEW: state_d = BLANK_1;
        BLANK_1:  state_d = SHOW_OLD;
        SHOW_OLD: state_d = BLANK_2;
        BLANK_2:  state_d = SHOW_NEW;
        default:  state_d = SHOW_NEW;
      endcase
    end else begin
      cnt_d = cnt_q + 1'b1;
    end

    // A digit slot stays dark until that history entry holds a real key
    case (state_d)
      SHOW_NEW: begin
        if (new_valid_d) begin
          anode_d = 2'b10;
          seg_d   = decode(new_digit_d);
        end
      end
      SHOW_OLD: begin
        if (old_valid_d) begin
          anode_d = 2'b01;
          seg_d   = decode(old_digit_d);
        end
      end
      default: begin
        anode_d = c_anode_off;
        seg_d   = c_seg_off;
      end
    endcase
  end

  // State, history and registered display outputs; reset wins over keys
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= SHOW_NEW;
      cnt_q       <= '0;
      new_digit_q <= 4'h0;
      old_digit_q <= 4'h0;
      new_valid_q <= 1'b0;
      old_valid_q <= 1'b0;
      anode_q     <= c_anode_off;
      seg_q       <= c_seg_off;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      new_digit_q <= new_digit_d;
      old_digit_q <= old_digit_d;
      new_valid_q <= new_valid_d;
      old_valid_q <= old_valid_d;
      anode_q     <= anode_d;
      seg_q       <= seg_d;
    end
  end

  assign current_value = new_digit_q;
  assign seg           = seg_q;
  assign anode         = anode_q;

endmodule
`default_nettype wire

// File: tb/tb_key_display_mux.sv
`default_nettype none
// ============================================================================
// Module      : tb_key_display_mux
// Description : Scoreboard bench for key_display_mux with REFRESH_CYCLES=4,
//               BLANK_CYCLES=2 (refresh period of 12 cycles).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_key_display_mux;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] input_key = 4'h0;
  logic       valid_input = 1'b0;
  logic [3:0] current_value;
  logic [6:0] seg;
  logic [1:0] anode;

  typedef struct {
    logic [1:0] anode;
    logic [6:0] seg;
    logic [3:0] cv;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc   = 0;

  // Reference: position within the 12-cycle period plus a two-entry history
  int         pos = 0;
  logic [3:0] m_new = 4'h0, m_old = 4'h0;
  logic       m_nv = 1'b0, m_ov = 1'b0;

  key_display_mux #(
    .REFRESH_CYCLES(4),
    .BLANK_CYCLES  (2)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .input_key    (input_key),
    .valid_input  (valid_input),
    .current_value(current_value),
    .seg          (seg),
    .anode        (anode)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] seg_of(input logic [3:0] h);
    logic [6:0] s;
    case (h)
      4'h0: s = 7'b1000000;  4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;  4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;  4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;  4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;  4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;  4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;  4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;  default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  // Apply one input vector across one edge and queue the expected response
  task automatic step(input logic r, input logic v, input logic [3:0] k);
    exp_t e;
    @(negedge clk);
    reset       = r;
    valid_input = v;
    input_key   = k;
    @(posedge clk);
    if (!r) begin
      pos  = 0;
      m_new = 4'h0; m_old = 4'h0;
      m_nv  = 1'b0; m_ov  = 1'b0;
    end else begin
      if (v) begin
        m_old = m_new; m_ov = m_nv;
        m_new = k;     m_nv = 1'b1;
      end
      pos = (pos + 1) % 12;
    end
    e.anode = 2'b11;
    e.seg   = 7'b1111111;
    e.cv    = m_new;
    if (pos < 4 && m_nv) begin
      e.anode = 2'b10;
      e.seg   = seg_of(m_new);
    end else if (pos >= 6 && pos < 10 && m_ov) begin
      e.anode = 2'b01;
      e.seg   = seg_of(m_old);
    end
    q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 4'h0);
  endtask

  task automatic run_to(input int p);
    for (int i = 0; i < 12 && pos != p; i++) step(1'b1, 1'b0, 4'h0);
  endtask

  // Monitor: every edge the DUT presents a new output set; check it
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (q.size() > 0) begin
        e = q.pop_front();
        n_vec++;
        if (anode !== e.anode || seg !== e.seg || current_value !== e.cv) begin
          n_err++;
          $display("FAIL outputs cycle %0d: anode=%b seg=%b current_value=%h, required anode=%b seg=%b current_value=%h",
                   cyc, anode, seg, current_value, e.anode, e.seg, e.cv);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  initial begin
    // Reset, then a fully dark display with no keys
    step(1'b0, 1'b0, 4'h0);
    step(1'b0, 1'b0, 4'h0);
    idle(24);

    // Single key 5 during SHOW_NEW; SHOW_OLD stays dark
    step(1'b1, 1'b1, 4'h5);
    idle(12);

    // Keys 3 then A: A on the right digit, 3 on the left
    step(1'b0, 1'b0, 4'h0);
    step(1'b1, 1'b1, 4'h3);
    step(1'b1, 1'b1, 4'hA);
    idle(24);

    // Valid held high for three keys 1,2,3
    step(1'b1, 1'b1, 4'h1);
    step(1'b1, 1'b1, 4'h2);
    step(1'b1, 1'b1, 4'h3);
    idle(12);

    // Key F on the terminal SHOW_NEW cycle lands with the move to BLANK_1
    run_to(3);
    step(1'b1, 1'b1, 4'hF);
    idle(8);

    // History {7,9}, reset mid SHOW_OLD with a key present
    step(1'b0, 1'b0, 4'h0);
    step(1'b1, 1'b1, 4'h7);
    step(1'b1, 1'b1, 4'h9);
    run_to(7);
    step(1'b0, 1'b1, 4'hE);
    step(1'b1, 1'b1, 4'h6);
    idle(14);

    repeat (3) @(posedge clk);
    #2;
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d expected vectors left unchecked, required 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
